// File: rtl/stack_control_fsm.sv
// Control sequencer for a two-stack machine: decodes one instruction per cycle into a
// registered control word, tracks data/return stack occupancy and traps stack faults.
module stack_control_fsm #(
    parameter int INST_W   = 16,
    parameter int DS_DEPTH = 16,
    parameter int RS_DEPTH = 8
) (
    input  logic                              CLK,
    input  logic                              reset,
    input  logic [INST_W-1:0]                 inst,
    input  logic                              inst_valid,
    input  logic                              mem_ready,
    output logic [2:0]                        stackOP,
    output logic [1:0]                        rStackOP,
    output logic [3:0]                        ALUOP,
    output logic [2:0]                        stackControl,
    output logic [2:0]                        PCControl,
    output logic                              MemWrite,
    output logic                              PCWrite,
    output logic [$clog2(DS_DEPTH+1)-1:0]     ds_count,
    output logic [$clog2(RS_DEPTH+1)-1:0]     rs_count,
    output logic                              halted,
    output logic                              fault,
    output logic [1:0]                        fault_code
);

    localparam int DSW  = $clog2(DS_DEPTH + 1);
    localparam int RSW  = $clog2(RS_DEPTH + 1);
    localparam int SUBW = INST_W - 4;

    localparam logic [DSW-1:0]  DS_FULL = DSW'(DS_DEPTH);
    localparam logic [RSW-1:0]  RS_FULL = RSW'(RS_DEPTH);
    localparam logic [SUBW-1:0] SUB_MAX = SUBW'(11);

    localparam logic [2:0] SOP_NONE   = 3'd0;
    localparam logic [2:0] SOP_PUSH   = 3'd1;
    localparam logic [2:0] SOP_POPREP = 3'd2;
    localparam logic [2:0] SOP_POP    = 3'd3;
    localparam logic [2:0] SOP_POP2   = 3'd4;
    localparam logic [2:0] SOP_SWAP   = 3'd5;

    localparam logic [1:0] ROP_NONE = 2'd0;
    localparam logic [1:0] ROP_PUSH = 2'd1;
    localparam logic [1:0] ROP_POP  = 2'd3;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_A      = 4'd5;
    localparam logic [3:0] ALU_B      = 4'd6;
    localparam logic [3:0] ALU_EQ     = 4'd7;
    localparam logic [3:0] ALU_EZ     = 4'd8;
    localparam logic [3:0] ALU_BLESSA = 4'd9;

    localparam logic [2:0] SC_IMM    = 3'd0;
    localparam logic [2:0] SC_IMMLUI = 3'd1;
    localparam logic [2:0] SC_MEM    = 3'd2;
    localparam logic [2:0] SC_ALU    = 3'd3;
    localparam logic [2:0] SC_INPUT  = 3'd4;

    localparam logic [2:0] PC_RETURN = 3'd0;
    localparam logic [2:0] PC_TOS    = 3'd1;
    localparam logic [2:0] PC_LABEL  = 3'd2;
    localparam logic [2:0] PC_LORINC = 3'd3;
    localparam logic [2:0] PC_PCINC  = 3'd4;

    localparam logic [3:0] OP_SYS   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BEZ   = 4'd2;
    localparam logic [3:0] OP_J     = 4'd3;
    localparam logic [3:0] OP_JAL   = 4'd4;
    localparam logic [3:0] OP_POP   = 4'd5;
    localparam logic [3:0] OP_PUSH  = 4'd6;
    localparam logic [3:0] OP_PUSHI = 4'd7;
    localparam logic [3:0] OP_LUI   = 4'd8;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_UNDER   = 2'd1;
    localparam logic [1:0] FC_OVER    = 2'd2;
    localparam logic [1:0] FC_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_HALTED, S_FAULT} state_t;

    typedef struct packed {
        logic [2:0] sop;
        logic [1:0] rop;
        logic [3:0] alu;
        logic [2:0] sctl;
        logic [2:0] pcc;
        logic       mw;
    } ctrl_t;

    localparam ctrl_t IDLE_CTRL = '{sop: SOP_NONE, rop: ROP_NONE, alu: ALU_ADD,
                                    sctl: SC_IMM, pcc: PC_PCINC, mw: 1'b0};

    state_t          state_q;
    ctrl_t           ctrl_q, ctrl_d, pend_ctrl_q;
    logic            pc_write_q;
    logic            halted_q, fault_q;
    logic [1:0]      fault_code_q, fault_code_d;
    logic [DSW-1:0]  ds_count_q, ds_count_d, pend_ds_q;
    logic [RSW-1:0]  rs_count_q, rs_count_d;

    logic [3:0]      opcode;
    logic [SUBW-1:0] subfn;
    logic [1:0]      ds_min;
    logic            ds_room, ds_up, ds_dn1, ds_dn2;
    logic            rs_up, rs_dn;
    logic            illegal, is_halt, is_mem;

    assign opcode = inst[INST_W-1:INST_W-4];
    assign subfn  = inst[INST_W-5:0];

    // Instruction decode: control word plus the stack requirements it carries.
    always_comb begin
        ctrl_d  = IDLE_CTRL;
        ds_min  = 2'd0;
        ds_room = 1'b0;
        ds_up   = 1'b0;
        ds_dn1  = 1'b0;
        ds_dn2  = 1'b0;
        rs_up   = 1'b0;
        rs_dn   = 1'b0;
        illegal = 1'b0;
        is_halt = 1'b0;
        is_mem  = 1'b0;
        case (opcode)
            OP_SYS: begin
                if (subfn > SUB_MAX) begin
                    illegal = 1'b1;
                end else begin
                    case (subfn[3:0])
                        4'd0: begin
                            ctrl_d.sop = SOP_POPREP; ctrl_d.alu = ALU_ADD; ctrl_d.sctl = SC_ALU;
                            ds_min = 2'd2; ds_dn1 = 1'b1;
                        end
                        4'd1: begin
                            ctrl_d.sop = SOP_PUSH; ctrl_d.alu = ALU_A; ctrl_d.sctl = SC_ALU;
                            ds_room = 1'b1; ds_up = 1'b1;
                        end
                        4'd2: begin
                            ctrl_d.sop = SOP_POP;
                            ds_min = 2'd1; ds_dn1 = 1'b1;
                        end
                        4'd3: is_halt = 1'b1;
                        4'd4: begin
                            ctrl_d.sop = SOP_PUSH; ctrl_d.sctl = SC_INPUT;
                            ds_room = 1'b1; ds_up = 1'b1;
                        end
                        4'd5: begin
                            ctrl_d.sop = SOP_POP; ctrl_d.pcc = PC_TOS;
                            ds_min = 2'd1; ds_dn1 = 1'b1;
                        end
                        4'd6: begin
                            ctrl_d.sop = SOP_PUSH; ctrl_d.alu = ALU_B; ctrl_d.sctl = SC_ALU;
                            ds_min = 2'd2; ds_room = 1'b1; ds_up = 1'b1;
                        end
                        4'd7: begin
                            ctrl_d.sop = SOP_POPREP; ctrl_d.alu = ALU_OR; ctrl_d.sctl = SC_ALU;
                            ds_min = 2'd2; ds_dn1 = 1'b1;
                        end
                        4'd8: begin
                            ctrl_d.rop = ROP_POP; ctrl_d.pcc = PC_RETURN;
                            rs_dn = 1'b1;
                        end
                        4'd9: begin
                            ctrl_d.sop = SOP_POPREP; ctrl_d.alu = ALU_BLESSA; ctrl_d.sctl = SC_ALU;
                            ds_min = 2'd2; ds_dn1 = 1'b1;
                        end
                        4'd10: begin
                            ctrl_d.sop = SOP_POPREP; ctrl_d.alu = ALU_SUB; ctrl_d.sctl = SC_ALU;
                            ds_min = 2'd2; ds_dn1 = 1'b1;
                        end
                        4'd11: begin
                            ctrl_d.sop = SOP_SWAP;
                            ds_min = 2'd2;
                        end
                        default: illegal = 1'b1;
                    endcase
                end
            end
            OP_BEQ: begin
                ctrl_d.sop = SOP_POP2; ctrl_d.alu = ALU_EQ; ctrl_d.pcc = PC_LORINC;
                ds_min = 2'd2; ds_dn2 = 1'b1;
            end
            OP_BEZ: begin
                ctrl_d.sop = SOP_POP; ctrl_d.alu = ALU_EZ; ctrl_d.pcc = PC_LORINC;
                ds_min = 2'd1; ds_dn1 = 1'b1;
            end
            OP_J: ctrl_d.pcc = PC_LABEL;
            OP_JAL: begin
                ctrl_d.rop = ROP_PUSH; ctrl_d.pcc = PC_LABEL;
                rs_up = 1'b1;
            end
            OP_POP: begin
                ctrl_d.sop = SOP_POP; ctrl_d.mw = 1'b1;
                ds_min = 2'd1; ds_dn1 = 1'b1; is_mem = 1'b1;
            end
            OP_PUSH: begin
                ctrl_d.sop = SOP_PUSH; ctrl_d.sctl = SC_MEM;
                ds_room = 1'b1; ds_up = 1'b1; is_mem = 1'b1;
            end
            OP_PUSHI: begin
                ctrl_d.sop = SOP_PUSH; ctrl_d.sctl = SC_IMM;
                ds_room = 1'b1; ds_up = 1'b1;
            end
            OP_LUI: begin
                ctrl_d.sop = SOP_PUSH; ctrl_d.sctl = SC_IMMLUI;
                ds_room = 1'b1; ds_up = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Underflow is tested before overflow so that over on a short stack reports underflow.
    always_comb begin
        fault_code_d = FC_NONE;
        ds_count_d   = ds_count_q;
        rs_count_d   = rs_count_q;
        if (illegal)
            fault_code_d = FC_ILLEGAL;
        else if (ds_count_q < DSW'(ds_min))
            fault_code_d = FC_UNDER;
        else if (ds_room && ds_count_q >= DS_FULL)
            fault_code_d = FC_OVER;
        else if (rs_dn && rs_count_q == '0)
            fault_code_d = FC_UNDER;
        else if (rs_up && rs_count_q >= RS_FULL)
            fault_code_d = FC_OVER;

        if (ds_up)
            ds_count_d = ds_count_q + DSW'(1);
        else if (ds_dn1)
            ds_count_d = ds_count_q - DSW'(1);
        else if (ds_dn2)
            ds_count_d = ds_count_q - DSW'(2);

        if (rs_up)
            rs_count_d = rs_count_q + RSW'(1);
        else if (rs_dn)
            rs_count_d = rs_count_q - RSW'(1);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= S_RUN;
            ctrl_q       <= IDLE_CTRL;
            pc_write_q   <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            ds_count_q   <= '0;
            rs_count_q   <= '0;
        end else begin
            ctrl_q     <= IDLE_CTRL;
            pc_write_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (inst_valid) begin
                        if (fault_code_d != FC_NONE) begin
                            state_q      <= S_FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= fault_code_d;
                        end else if (is_halt) begin
                            state_q  <= S_HALTED;
                            halted_q <= 1'b1;
                        end else if (is_mem) begin
                            state_q     <= S_MEMWAIT;
                            pend_ctrl_q <= ctrl_d;
                            pend_ds_q   <= ds_count_d;
                        end else begin
                            ctrl_q     <= ctrl_d;
                            pc_write_q <= 1'b1;
                            ds_count_q <= ds_count_d;
                            rs_count_q <= rs_count_d;
                        end
                    end
                end
                S_MEMWAIT: begin
                    if (mem_ready) begin
                        state_q    <= S_RUN;
                        ctrl_q     <= pend_ctrl_q;
                        pc_write_q <= 1'b1;
                        ds_count_q <= pend_ds_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stackOP      = ctrl_q.sop;
    assign rStackOP     = ctrl_q.rop;
    assign ALUOP        = ctrl_q.alu;
    assign stackControl = ctrl_q.sctl;
    assign PCControl    = ctrl_q.pcc;
    assign MemWrite     = ctrl_q.mw;
    assign PCWrite      = pc_write_q;
    assign ds_count     = ds_count_q;
    assign rs_count     = rs_count_q;
    assign halted       = halted_q;
    assign fault        = fault_q;
    assign fault_code   = fault_code_q;

endmodule

// File: tb/tb_stack_control_fsm.sv
// Directed scoreboard bench for stack_control_fsm with DS_DEPTH=4, RS_DEPTH=2 so that
// stack limits are reachable in a few instructions.
module tb_stack_control_fsm;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] inst = 16'h0;
    logic        inst_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  stackOP;
    logic [1:0]  rStackOP;
    logic [3:0]  ALUOP;
    logic [2:0]  stackControl;
    logic [2:0]  PCControl;
    logic        MemWrite;
    logic        PCWrite;
    logic [2:0]  ds_count;
    logic [1:0]  rs_count;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;

    stack_control_fsm #(.INST_W(16), .DS_DEPTH(4), .RS_DEPTH(2)) dut (
        .CLK(CLK), .reset(reset), .inst(inst), .inst_valid(inst_valid),
        .mem_ready(mem_ready), .stackOP(stackOP), .rStackOP(rStackOP), .ALUOP(ALUOP),
        .stackControl(stackControl), .PCControl(PCControl), .MemWrite(MemWrite),
        .PCWrite(PCWrite), .ds_count(ds_count), .rs_count(rs_count), .halted(halted),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] sop;
        logic [1:0] rop;
        logic [3:0] alu;
        logic [2:0] sctl;
        logic [2:0] pcc;
        logic       mw;
        logic       pw;
        logic [2:0] ds;
        logic [1:0] rs;
        logic       h;
        logic       f;
        logic [1:0] fc;
    } exp_t;

    exp_t  expq[$];
    string nameq[$];
    int    checks = 0;
    int    errors = 0;

    function automatic exp_t mk(input int sop, input int rop, input int alu, input int sctl,
                                input int pcc, input int mw, input int pw, input int ds,
                                input int rs, input int h, input int f, input int fc);
        exp_t e;
        e.sop = 3'(sop);  e.rop = 2'(rop);  e.alu = 4'(alu);  e.sctl = 3'(sctl);
        e.pcc = 3'(pcc);  e.mw = 1'(mw);    e.pw = 1'(pw);    e.ds = 3'(ds);
        e.rs = 2'(rs);    e.h = 1'(h);      e.f = 1'(f);      e.fc = 2'(fc);
        return e;
    endfunction

    function automatic exp_t idl(input int ds, input int rs, input int h, input int f, input int fc);
        return mk(0, 0, 0, 0, 4, 0, 0, ds, rs, h, f, fc);
    endfunction

    // Drive one cycle of stimulus and queue the control state expected after that edge.
    task automatic step(input string nm, input logic r, input logic v, input logic [15:0] i,
                        input logic mr, input exp_t e);
        @(negedge CLK);
        reset      = r;
        inst_valid = v;
        inst       = i;
        mem_ready  = mr;
        expq.push_back(e);
        nameq.push_back(nm);
    endtask

    // Monitor: every registered output word is compared with the oldest expectation.
    initial begin
        exp_t  act, ex;
        string nm;
        forever begin
            @(posedge CLK);
            #1;
            if (expq.size() > 0) begin
                ex = expq.pop_front();
                nm = nameq.pop_front();
                act = {stackOP, rStackOP, ALUOP, stackControl, PCControl, MemWrite, PCWrite,
                       ds_count, rs_count, halted, fault, fault_code};
                checks++;
                if (act !== ex) begin
                    errors++;
                    $display("FAIL %s got sop=%0d rop=%0d alu=%0d sctl=%0d pcc=%0d mw=%0d pw=%0d ds=%0d rs=%0d h=%0d f=%0d fc=%0d want sop=%0d rop=%0d alu=%0d sctl=%0d pcc=%0d mw=%0d pw=%0d ds=%0d rs=%0d h=%0d f=%0d fc=%0d",
                             nm, act.sop, act.rop, act.alu, act.sctl, act.pcc, act.mw, act.pw,
                             act.ds, act.rs, act.h, act.f, act.fc,
                             ex.sop, ex.rop, ex.alu, ex.sctl, ex.pcc, ex.mw, ex.pw,
                             ex.ds, ex.rs, ex.h, ex.f, ex.fc);
                end
            end
        end
    end

    initial begin
        step("rst0",        1, 0, 16'h0000, 0, idl(0, 0, 0, 0, 0));
        step("rst_prio",    1, 1, 16'h7001, 1, idl(0, 0, 0, 0, 0));
        step("pushi1",      0, 1, 16'h7005, 0, mk(1, 0, 0, 0, 4, 0, 1, 1, 0, 0, 0, 0));
        step("pushi2",      0, 1, 16'h7006, 0, mk(1, 0, 0, 0, 4, 0, 1, 2, 0, 0, 0, 0));
        step("pushi3",      0, 1, 16'h7007, 0, mk(1, 0, 0, 0, 4, 0, 1, 3, 0, 0, 0, 0));
        step("add",         0, 1, 16'h0000, 0, mk(2, 0, 0, 3, 4, 0, 1, 2, 0, 0, 0, 0));
        step("bubble",      0, 0, 16'h0000, 0, idl(2, 0, 0, 0, 0));
        step("push_dec",    0, 1, 16'h6010, 0, idl(2, 0, 0, 0, 0));
        step("push_wait1",  0, 1, 16'h7000, 0, idl(2, 0, 0, 0, 0));
        step("push_wait2",  0, 1, 16'h7000, 0, idl(2, 0, 0, 0, 0));
        step("push_wait3",  0, 1, 16'h7000, 0, idl(2, 0, 0, 0, 0));
        step("push_done",   0, 0, 16'h0000, 1, mk(1, 0, 0, 2, 4, 0, 1, 3, 0, 0, 0, 0));
        step("bubble2",     0, 0, 16'h0000, 1, idl(3, 0, 0, 0, 0));
        step("dup",         0, 1, 16'h0001, 0, mk(1, 0, 5, 3, 4, 0, 1, 4, 0, 0, 0, 0));
        step("swap",        0, 1, 16'h000B, 0, mk(5, 0, 0, 0, 4, 0, 1, 4, 0, 0, 0, 0));
        step("sub",         0, 1, 16'h000A, 0, mk(2, 0, 1, 3, 4, 0, 1, 3, 0, 0, 0, 0));
        step("or",          0, 1, 16'h0007, 0, mk(2, 0, 3, 3, 4, 0, 1, 2, 0, 0, 0, 0));
        step("slt",         0, 1, 16'h0009, 0, mk(2, 0, 9, 3, 4, 0, 1, 1, 0, 0, 0, 0));
        step("getin",       0, 1, 16'h0004, 0, mk(1, 0, 0, 4, 4, 0, 1, 2, 0, 0, 0, 0));
        step("over",        0, 1, 16'h0006, 0, mk(1, 0, 6, 3, 4, 0, 1, 3, 0, 0, 0, 0));
        step("beq",         0, 1, 16'h1020, 0, mk(4, 0, 7, 0, 3, 0, 1, 1, 0, 0, 0, 0));
        step("lui",         0, 1, 16'h8012, 0, mk(1, 0, 0, 1, 4, 0, 1, 2, 0, 0, 0, 0));
        step("bez",         0, 1, 16'h2030, 0, mk(3, 0, 8, 0, 3, 0, 1, 1, 0, 0, 0, 0));
        step("js",          0, 1, 16'h0005, 0, mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        step("j",           0, 1, 16'h3040, 0, mk(0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0));
        step("jal1",        0, 1, 16'h4050, 0, mk(0, 1, 0, 0, 2, 0, 1, 0, 1, 0, 0, 0));
        step("jal2",        0, 1, 16'h4060, 0, mk(0, 1, 0, 0, 2, 0, 1, 0, 2, 0, 0, 0));
        step("jal_ovf",     0, 1, 16'h4070, 0, idl(0, 2, 0, 1, 2));
        step("fault_hold",  0, 1, 16'h7001, 0, idl(0, 2, 0, 1, 2));
        step("rst_a",       1, 0, 16'h0000, 0, idl(0, 0, 0, 0, 0));
        step("jal3",        0, 1, 16'h4080, 0, mk(0, 1, 0, 0, 2, 0, 1, 0, 1, 0, 0, 0));
        step("return",      0, 1, 16'h0008, 0, mk(0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        step("return_unf",  0, 1, 16'h0008, 0, idl(0, 0, 0, 1, 1));
        step("rst_b",       1, 0, 16'h0000, 0, idl(0, 0, 0, 0, 0));
        step("pushi_b",     0, 1, 16'h7009, 0, mk(1, 0, 0, 0, 4, 0, 1, 1, 0, 0, 0, 0));
        step("pop_dec",     0, 1, 16'h5000, 1, idl(1, 0, 0, 0, 0));
        step("pop_done",    0, 0, 16'h0000, 1, mk(3, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0));
        step("drop_unf",    0, 1, 16'h0002, 0, idl(0, 0, 0, 1, 1));
        step("unf_hold1",   0, 0, 16'h0000, 0, idl(0, 0, 0, 1, 1));
        step("unf_hold2",   0, 1, 16'h0000, 1, idl(0, 0, 0, 1, 1));
        step("rst_c",       1, 0, 16'h0000, 0, idl(0, 0, 0, 0, 0));
        for (int k = 1; k <= 4; k++)
            step($sformatf("fill%0d", k), 0, 1, 16'h7000, 0, mk(1, 0, 0, 0, 4, 0, 1, k, 0, 0, 0, 0));
        step("pushi_ovf",   0, 1, 16'h7000, 0, idl(4, 0, 0, 1, 2));
        step("rst_d",       1, 0, 16'h0000, 0, idl(0, 0, 0, 0, 0));
        step("ill_900C",    0, 1, 16'h900C, 0, idl(0, 0, 0, 1, 3));
        step("rst_e",       1, 0, 16'h0000, 0, idl(0, 0, 0, 0, 0));
        step("ill_000C",    0, 1, 16'h000C, 0, idl(0, 0, 0, 1, 3));
        step("rst_f",       1, 0, 16'h0000, 0, idl(0, 0, 0, 0, 0));
        step("pushi_f",     0, 1, 16'h7001, 0, mk(1, 0, 0, 0, 4, 0, 1, 1, 0, 0, 0, 0));
        step("push_dec2",   0, 1, 16'h6000, 0, idl(1, 0, 0, 0, 0));
        step("push_wait4",  0, 0, 16'h0000, 0, idl(1, 0, 0, 0, 0));
        step("rst_memwait", 1, 1, 16'h7000, 1, idl(0, 0, 0, 0, 0));
        step("post_rst",    0, 0, 16'h0000, 1, idl(0, 0, 0, 0, 0));
        step("pushi_g",     0, 1, 16'h7002, 0, mk(1, 0, 0, 0, 4, 0, 1, 1, 0, 0, 0, 0));
        step("halt",        0, 1, 16'h0003, 0, idl(1, 0, 1, 0, 0));
        step("halt_hold1",  0, 1, 16'h7000, 0, idl(1, 0, 1, 0, 0));
        step("halt_hold2",  0, 1, 16'h0000, 1, idl(1, 0, 1, 0, 0));
        step("rst_g",       1, 0, 16'h0000, 0, idl(0, 0, 0, 0, 0));
        step("pop_unf",     0, 1, 16'h5000, 0, idl(0, 0, 0, 1, 1));
        step("pop_unf_hold",0, 0, 16'h0000, 1, idl(0, 0, 0, 1, 1));
        step("rst_h",       1, 0, 16'h0000, 0, idl(0, 0, 0, 0, 0));
        step("pushi_h",     0, 1, 16'h7003, 0, mk(1, 0, 0, 0, 4, 0, 1, 1, 0, 0, 0, 0));
        step("over_unf",    0, 1, 16'h0006, 0, idl(1, 0, 0, 1, 1));
        step("rst_end",     1, 0, 16'h0000, 0, idl(0, 0, 0, 0, 0));
        @(negedge CLK);
        reset      = 1'b0;
        inst_valid = 1'b0;
        for (int k = 0; k < 8 && expq.size() > 0; k++) begin
            @(posedge CLK);
            #2;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0 pending", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
